// File: rtl/ysyx_23060111_mem_pkg.sv
// Shared definitions for the data-memory responder.
// Holds the byte-count encodings used on the EXU load/store port, the responder
// FSM states, and helpers that turn a byte count plus byte lane into a byte-enable
// strobe or a right-justified data mask.
package ysyx_23060111_mem_pkg;

  // Byte counts, same encoding as the core's m_rmask / m_wmask.
  localparam logic [3:0] SZ_B = 4'd1;
  localparam logic [3:0] SZ_H = 4'd2;
  localparam logic [3:0] SZ_W = 4'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Byte enables for an access of 'size' bytes starting at byte 'lane' of a word.
  // An unsupported size yields no enables at all.
  function automatic logic [3:0] strobe(input logic [3:0] size, input logic [1:0] lane);
    logic [3:0] base;
    case (size)
      SZ_B:    base = 4'b0001;
      SZ_H:    base = 4'b0011;
      SZ_W:    base = 4'b1111;
      default: base = 4'b0000;
    endcase
    return base << lane;
  endfunction

  // Mask that keeps the low 'size' bytes of right-justified data.
  function automatic logic [31:0] size_mask(input logic [3:0] size);
    case (size)
      SZ_B:    return 32'h0000_00FF;
      SZ_H:    return 32'h0000_FFFF;
      SZ_W:    return 32'hFFFF_FFFF;
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_23060111_dmem_bank.sv
// Word-organised SRAM array for the data-memory responder.
// One synchronous read/write port with four byte enables. A read registers the
// addressed word into rdata, which then holds until the next enabled read.
// Ports:
//   clk    in   clock
//   en     in   port enable (one access this edge)
//   we     in   1 = write the enabled bytes, 0 = read
//   be     in   4  byte enables for writes
//   addr   in   AW word address
//   wdata  in   32 write data, already lane-aligned
//   rdata  out  32 registered read data
module ysyx_23060111_dmem_bank #(
  parameter int DEPTH = 4096,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // NOTE: the array and its read register have no reset; contents are undefined
  // after power-up, and a reset branch here would stop the array mapping to SRAM.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) begin
            mem[addr][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/ysyx_23060111_dmem_responder.sv
// Data-memory responder: slave end of the EXU load/store port.
// Accepts one load/store at a time, waits LATENCY cycles, performs the access on a
// single edge, then presents the response until the EXU takes it. Load data is
// returned right-justified and zero-filled above the access size; the EXU does any
// sign extension. Misaligned, bad-size and out-of-range requests report resp_err
// and never touch the array.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_we                1 = store, 0 = load
//   req_addr              byte address
//   req_size              byte count 1/2/4
//   req_wdata             store data, right-justified
//   resp_valid/resp_ready response handshake
//   resp_rdata            load data, right-justified; 0 for stores and errors
//   resp_err              misaligned / bad size / out of range
module ysyx_23060111_dmem_responder
  import ysyx_23060111_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          DEPTH     = 4096,
  parameter int          LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;
  localparam logic [3:0]  LAT  = 4'(LATENCY);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  size_q;
  logic [31:0] wdata_q;

  // Decode of the latched request; stable for the whole WAIT/RESP window.
  logic [31:0] off;
  logic [1:0]  lane;
  logic        size_ok, align_ok, range_ok, err;
  logic        access;
  logic [31:0] bank_rdata;
  logic [31:0] load_data;

  assign off  = addr_q - BASE_ADDR;
  assign lane = off[1:0];

  assign size_ok  = (size_q == SZ_B) || (size_q == SZ_H) || (size_q == SZ_W);
  assign align_ok = (size_q == SZ_B) ||
                    ((size_q == SZ_H) && !lane[0]) ||
                    ((size_q == SZ_W) && (lane == 2'd0));
  // The explicit lower-bound test keeps addresses below BASE_ADDR from wrapping
  // around the subtraction into the served window.
  assign range_ok = (addr_q >= BASE_ADDR) && ({1'b0, off} < SPAN);
  assign err      = !(size_ok && align_ok && range_ok);

  assign access = (state_q == WAIT) && (cnt_q == 4'd0);

  ysyx_23060111_dmem_bank #(
    .DEPTH (DEPTH)
  ) u_bank (
    .clk   (clk),
    .en    (access && !err),
    .we    (we_q),
    .be    (strobe(size_q, lane)),
    .addr  (off[AW+1:2]),
    .wdata (wdata_q << {lane, 3'b000}),
    .rdata (bank_rdata)
  );

  assign load_data = (bank_rdata >> {lane, 3'b000}) & size_mask(size_q);

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = (state_q == RESP) && err;
  assign resp_rdata = ((state_q == RESP) && !we_q && !err) ? load_data : 32'h0;

  // NOTE: every output of this block gets its default first, so no path through
  // the case can leave state_d unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid)     state_d = WAIT;
      WAIT:    if (cnt_q == 4'd0) state_d = RESP;
      RESP:    if (resp_ready)    state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register here
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      size_q  <= 4'd0;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && req_valid) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        size_q  <= req_size;
        wdata_q <= req_wdata;
        cnt_q   <= LAT;
      end else if ((state_q == WAIT) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060111_dmem_responder.sv
// Self-checking bench for the data-memory responder. Two instances share clock
// and reset: index 0 uses the default LATENCY=2, index 1 uses LATENCY=0.
// A byte-addressed model computes every expected response; a compare process
// checks each cycle a response is presented.
module tb_ysyx_23060111_dmem_responder;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 4096;
  localparam int          LAT0  = 2;
  localparam int          LAT1  = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic [1:0]        req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
  logic [1:0][31:0]  req_addr, req_wdata, resp_rdata;
  logic [1:0][3:0]   req_size;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  logic [1:0][31:0] exp_rdata;
  logic [1:0]       exp_err;
  logic [1:0]       exp_active;

  // Model memory: one byte per (instance, byte address).
  logic [7:0] mem_m [longint];

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  ysyx_23060111_dmem_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(LAT0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_size(req_size[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  ysyx_23060111_dmem_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(LAT1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_size(req_size[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  function automatic longint key(input int d, input logic [31:0] a);
    return (longint'(d) << 32) | longint'({32'h0, a});
  endfunction

  // Applies one request to the model: validity by the addressing rules, then a
  // byte-by-byte store or right-justified load.
  function automatic void model_access(input int d, input logic we, input logic [31:0] addr,
                                       input logic [3:0] size, input logic [31:0] wdata,
                                       output logic [31:0] rdata, output logic err);
    longint off;
    int n;
    off   = longint'({32'h0, addr}) - longint'({32'h0, BASE});
    n     = int'(size);
    err   = 1'b0;
    rdata = 32'h0;
    if (n != 1 && n != 2 && n != 4)                err = 1'b1;
    else if (off < 0 || off >= longint'(DEPTH) * 4) err = 1'b1;
    else if ((off % n) != 0)                        err = 1'b1;
    if (!err) begin
      for (int i = 0; i < n; i++) begin
        longint k;
        k = key(d, addr + 32'(i));
        if (we) mem_m[k] = wdata[8*i +: 8];
        else    rdata[8*i +: 8] = mem_m.exists(k) ? mem_m[k] : 8'hxx;
      end
    end
  endfunction

  // Compare process: any presented response must match the model's expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (resp_valid[d]) begin
          check($sformatf("resp_expected%0d", d), 32'(exp_active[d]), 32'd1);
          check($sformatf("resp_rdata%0d", d), resp_rdata[d], exp_rdata[d]);
          check($sformatf("resp_err%0d", d), 32'(resp_err[d]), 32'(exp_err[d]));
          check($sformatf("req_ready_in_resp%0d", d), 32'(req_ready[d]), 32'd0);
        end
      end
    end
  end

  // One transaction, started away from a rising edge. 'hold' cycles of response
  // backpressure, during which stray request pulses are driven.
  task automatic do_txn(input int d, input logic we, input logic [31:0] addr,
                        input logic [3:0] size, input logic [31:0] wdata, input int hold,
                        output logic [31:0] got_rdata, output logic got_err, output int acc_edge);
    logic [31:0] mr;
    logic        me;
    int          edges;
    bit          ok;
    model_access(d, we, addr, size, wdata, mr, me);
    req_we[d]     = we;
    req_addr[d]   = addr;
    req_size[d]   = size;
    req_wdata[d]  = wdata;
    req_valid[d]  = 1'b1;
    resp_ready[d] = (hold == 0);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready[d]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("accept_bound", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    acc_edge      = edge_cnt;
    exp_rdata[d]  = mr;
    exp_err[d]    = me;
    exp_active[d] = 1'b1;
    // Scramble the request lines; the latched copy must be used.
    req_valid[d] = 1'b0;
    req_we[d]    = ~we;
    req_addr[d]  = ~addr;
    req_size[d]  = 4'd3;
    req_wdata[d] = ~wdata;
    edges = 1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp_valid[d]) begin ok = 1'b1; break; end
      @(posedge clk);
      edges++;
    end
    check("resp_bound", 32'(ok), 32'd1);
    check("latency", 32'(edges), 32'(((d == 0) ? LAT0 : LAT1) + 2));
    got_rdata = resp_rdata[d];
    got_err   = resp_err[d];
    for (int i = 0; i < hold; i++) begin
      req_valid[d] = i[0];
      req_we[d]    = 1'b1;
      req_addr[d]  = BASE + 32'h40;
      req_size[d]  = 4'd4;
      req_wdata[d] = 32'hFFFF_FFFF;
      @(negedge clk);
    end
    req_valid[d]  = 1'b0;
    resp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    exp_active[d] = 1'b0;
    if (hold != 0) resp_ready[d] = 1'b0;
    @(negedge clk);
    check("idle_after_handshake", 32'({resp_valid[d], req_ready[d]}), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic        e;
    int          a0, a1, a2, a3;

    req_valid = '0; req_we = '0; req_addr = '0; req_size = '0; req_wdata = '0;
    resp_ready = '0; exp_rdata = '0; exp_err = '0; exp_active = '0;

    #2 rst_n = 1'b0;
    #2;
    for (int d = 0; d < 2; d++) begin
      check("reset_resp_valid", 32'(resp_valid[d]), 32'd0);
      check("reset_req_ready",  32'(req_ready[d]),  32'd1);
      check("reset_rdata",      resp_rdata[d],      32'd0);
      check("reset_err",        32'(resp_err[d]),   32'd0);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: word store then load
    do_txn(0, 1'b1, 32'h8000_0010, 4'd4, 32'hDEAD_BEEF, 0, r, e, a0);
    check("t1_sw_err", 32'(e), 32'd0);
    do_txn(0, 1'b0, 32'h8000_0010, 4'd4, 32'h0, 0, r, e, a0);
    check("t1_lw_data", r, 32'hDEAD_BEEF);
    check("t1_lw_err", 32'(e), 32'd0);

    // 2: byte store into a known word, word/byte/half loads
    do_txn(0, 1'b1, 32'h8000_0010, 4'd4, 32'h1122_3344, 0, r, e, a0);
    do_txn(0, 1'b1, 32'h8000_0013, 4'd1, 32'h0000_00A5, 0, r, e, a0);
    do_txn(0, 1'b0, 32'h8000_0010, 4'd4, 32'h0, 0, r, e, a0);
    check("t2_lw_merged", r, 32'hA522_3344);
    do_txn(0, 1'b0, 32'h8000_0013, 4'd1, 32'h0, 0, r, e, a0);
    check("t2_lb_no_sext", r, 32'h0000_00A5);
    do_txn(0, 1'b0, 32'h8000_0012, 4'd2, 32'h0, 0, r, e, a0);
    check("t2_lh_upper", r, 32'h0000_A522);

    // 3: error cases
    do_txn(0, 1'b0, 32'h8000_0011, 4'd2, 32'h0, 0, r, e, a0);
    check("t3_lh_mis_err", 32'(e), 32'd1);
    check("t3_lh_mis_data", r, 32'h0);
    do_txn(0, 1'b1, 32'h8000_0012, 4'd4, 32'hFFFF_FFFF, 0, r, e, a0);
    check("t3_sw_mis_err", 32'(e), 32'd1);
    do_txn(0, 1'b0, 32'h8000_0010, 4'd4, 32'h0, 0, r, e, a0);
    check("t3_word_unchanged", r, 32'hA522_3344);
    do_txn(0, 1'b0, 32'h8000_0010, 4'd3, 32'h0, 0, r, e, a0);
    check("t3_size3_err", 32'(e), 32'd1);
    do_txn(0, 1'b1, 32'h8000_0010, 4'd0, 32'h0, 0, r, e, a0);
    do_txn(0, 1'b0, 32'h7FFF_FFFC, 4'd4, 32'h0, 0, r, e, a0);
    check("t3_below_base_err", 32'(e), 32'd1);
    do_txn(0, 1'b0, BASE + 32'(DEPTH * 4), 4'd4, 32'h0, 0, r, e, a0);
    check("t3_past_end_err", 32'(e), 32'd1);
    do_txn(0, 1'b0, 32'h0000_0010, 4'd4, 32'h0, 0, r, e, a0);
    check("t3_wrap_err", 32'(e), 32'd1);
    do_txn(0, 1'b1, BASE + 32'(DEPTH * 4 - 4), 4'd4, 32'h0BAD_F00D, 0, r, e, a0);
    do_txn(0, 1'b0, BASE + 32'(DEPTH * 4 - 4), 4'd4, 32'h0, 0, r, e, a0);
    check("t3_last_word", r, 32'h0BAD_F00D);

    // 4: backpressure with stray request pulses aimed at word 0x40
    do_txn(0, 1'b1, 32'h8000_0040, 4'd4, 32'h55AA_55AA, 0, r, e, a0);
    do_txn(0, 1'b0, 32'h8000_0010, 4'd4, 32'h0, 5, r, e, a0);
    check("t4_bp_data", r, 32'hA522_3344);
    do_txn(0, 1'b1, 32'h8000_0044, 4'd2, 32'h0000_1357, 5, r, e, a0);
    do_txn(0, 1'b0, 32'h8000_0040, 4'd4, 32'h0, 0, r, e, a0);
    check("t4_no_stray_write", r, 32'h55AA_55AA);
    do_txn(0, 1'b0, 32'h8000_0044, 4'd4, 32'h0, 0, r, e, a0);
    check("t4_bp_store", r & 32'h0000_FFFF, 32'h0000_1357);

    // 5: zero-latency instance, back-to-back
    do_txn(1, 1'b1, 32'h8000_0010, 4'd4, 32'h0102_0304, 0, r, e, a0);
    do_txn(1, 1'b0, 32'h8000_0010, 4'd4, 32'h0, 0, r, e, a1);
    check("t5_lw0", r, 32'h0102_0304);
    do_txn(1, 1'b1, 32'h8000_0016, 4'd2, 32'h0000_BEEF, 0, r, e, a2);
    do_txn(1, 1'b0, 32'h8000_0016, 4'd2, 32'h0, 0, r, e, a3);
    check("t5_lh", r, 32'h0000_BEEF);
    check("t5_spacing01", 32'(a1 - a0), 32'd3);
    check("t5_spacing12", 32'(a2 - a1), 32'd3);
    check("t5_spacing23", 32'(a3 - a2), 32'd3);
    resp_ready[1] = 1'b0;

    // 6: reset during WAIT drops the store
    do_txn(0, 1'b1, 32'h8000_0020, 4'd4, 32'hCAFE_F00D, 0, r, e, a0);
    req_we[0] = 1'b1; req_addr[0] = 32'h8000_0020; req_size[0] = 4'd4;
    req_wdata[0] = 32'h1234_5678; req_valid[0] = 1'b1;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_resp_valid", 32'(resp_valid[0]), 32'd0);
    check("t6_rst_req_ready",  32'(req_ready[0]),  32'd1);
    check("t6_rst_rdata",      resp_rdata[0],      32'd0);
    check("t6_rst_err",        32'(resp_err[0]),   32'd0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_txn(0, 1'b0, 32'h8000_0020, 4'd4, 32'h0, 0, r, e, a0);
    check("t6_prior_contents", r, 32'hCAFE_F00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
